mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter and sequencer for the single-ported, byte-addressed unified memory (256 bytes, 32-bit data) that holds both program and data. It sits between the CPU's instruction-fetch unit and load/store unit on one side and the memory's control/data port on the other. It serialises their accesses with round-robin priority, rejects misaligned accesses, and returns registered read data with a one-cycle completion pulse per access.

## Interface
- AW, 8: address width (bytes).
- DW, 32: data width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- if_req  in  1  fetch request; held with if_addr until if_done.
- if_addr  in  AW  fetch byte address; word-aligned required.
- if_rdata  out  DW  fetched word; valid from if_done, held until next fetch completion.
- if_done  out  1  one-cycle completion pulse.
- if_err  out  1  qualifies if_done; misaligned, no memory access made.
- d_req  in  1  data request; held with all d_* fields until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_by, d_half  in  1 each  size: byte / halfword / word when both 0; d_by wins if both set.
- d_unsign  in  1  zero-extend loads.
- d_addr  in  AW  data byte address.
- d_wdata  in  DW  store data, little-endian.
- d_rdata  out  DW  load result; valid from d_done, held until next load completion.
- d_done, d_err  out  1 each  as for fetch port.
- mem_read, mem_write, mem_by, mem_half, mem_unsign  out  1 each  memory controls.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, combinational from mem_addr.
- busy  out  1  high while state = ACCESS.

## Operation
- States: IDLE, ACCESS. Reset → IDLE.
- IDLE: eligible port = req high and done not asserted this cycle for that port. A port's own done cycle ignores its req, so a held req is never re-granted.
- One eligible port: grant it. Both eligible: grant the port not in last_grant.
  - last_grant resets to DATA, so fetch wins the first tie.
- Alignment check on grant:
  - Fetch requires addr[1:0]=00.
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=00.
  - Byte is always legal.
  - Aligned accesses never wrap past address 255.
- Legal grant: latch addr, size, unsign, we, wdata and port id; go to ACCESS; update last_grant.
- Illegal grant: stay IDLE; next cycle pulse done+err for that port; rdata unchanged; last_grant updated.
- ACCESS, one cycle:
  - Fetch drives mem_read=1 with word size.
  - Data drives mem_read=!we and mem_write=we with the latched size and unsign.
  - End of cycle: a read captures mem_rdata into the port's rdata register; a write captures nothing. Set that port's done for the next cycle; return to IDLE.
- mem_* outputs decode purely from registers; all are 0 outside ACCESS, except mem_addr and mem_wdata, which hold their last value.
- Sign and zero extension are done by the memory; the arbiter passes mem_rdata through unchanged.

## Timing
- Req first seen in IDLE at cycle T → ACCESS at T+1 (mem controls high exactly that cycle) → done at T+2; rdata valid at T+2.
- Error path: done+err at T+1.
- Peak throughput: one access per 2 cycles. With both requesters continuously requesting, grants alternate F, D, F, D.
- In a done cycle, IDLE may grant the other port, so back-to-back accesses from different ports are gap-free.
- Reset outputs: every done, err, mem_* control, busy = 0; rdata, mem_addr, mem_wdata = 0; state IDLE; last_grant = DATA.
- Reset sampled while in ACCESS: the write at that same edge still occurs in memory because controls were already driven. All arbiter state clears, no done is issued, and the requester must re-request.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ACCESS), port-id constants (PORT_IF, PORT_D), size encoding (SZ_B, SZ_H, SZ_W) with a function mapping by/half to size.
- Sub-module mem_align_chk: combinational size + addr[1:0] → legal.
- Remainder (FSM, round-robin, latches, response registers) lives in mem_arbiter.

## Test plan
- Memory preloaded from its reset image. Fetch addr 0 → if_done at T+2, if_rdata=0x00000013; mem_read high exactly one cycle.
- Same cycle after reset: fetch addr 4 and load word addr 104 both requested → fetch served first (if_rdata=0x000010B7), then d_rdata=0x00000009; no idle cycle between the two accesses.
- Store byte 0x80 to addr 110, then lb addr 110 → 0xFFFFFF80; lbu → 0x00000080; store produces d_done without d_rdata change.
- Load word addr 101 and halfword addr 103 → d_done+d_err one cycle after grant; mem_read/mem_write never asserted.
- Both requesters hold req for 8 completions → grants strictly alternate; no completion for a port without a prior req.
- Reset asserted during ACCESS of a load → no d_done, outputs zero next cycle, state IDLE; re-request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, requester ids, access sizes.
// Pure declarations; no timing or flow-control behaviour of its own.
// Consumers: mem_arbiter and mem_align_chk.
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Byte takes precedence when both size bits are set.
    function automatic size_t to_size(input logic by, input logic half);
        if (by)
            return SZ_B;
        if (half)
            return SZ_H;
        return SZ_W;
    endfunction

endpackage

// File: rtl/mem_align_chk.sv
// Alignment legality for one access: size plus the two low address bits.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module mem_align_chk
    import mem_arb_pkg::*;
(
    input  size_t      size,
    input  logic [1:0] addr_lo,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        case (size)
            SZ_B:    legal = 1'b1;
            SZ_H:    legal = ~addr_lo[0];
            SZ_W:    legal = (addr_lo == 2'b00);
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer between fetch and load/store ports of a single-ported memory.
// Latency: grant in IDLE, one ACCESS cycle, done two cycles after request (error: one cycle).
// Backpressure: requesters hold req until their done pulse; the other port waits in IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_err,

    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_by,
    input  logic          d_half,
    input  logic          d_unsign,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_err,

    output logic          mem_read,
    output logic          mem_write,
    output logic          mem_by,
    output logic          mem_half,
    output logic          mem_unsign,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    state_t state;
    logic   last_grant;
    logic   cur_port;
    size_t  lat_size;
    logic   lat_unsign;
    logic   lat_we;

    logic   if_elig;
    logic   d_elig;
    logic   gnt_vld;
    logic   gnt_port;
    logic   gnt_legal;
    size_t  gnt_size;
    logic [1:0] gnt_lo;

    // A port's own done cycle masks its still-high req so it is not granted twice.
    always_comb begin
        if_elig  = if_req && !if_done;
        d_elig   = d_req && !d_done;
        gnt_vld  = (state == IDLE) && (if_elig || d_elig);
        if (if_elig && d_elig)
            gnt_port = ~last_grant;
        else
            gnt_port = d_elig ? PORT_D : PORT_IF;
        gnt_size = (gnt_port == PORT_IF) ? SZ_W : to_size(d_by, d_half);
        gnt_lo   = (gnt_port == PORT_IF) ? if_addr[1:0] : d_addr[1:0];
    end

    mem_align_chk u_align_chk (
        .size    (gnt_size),
        .addr_lo (gnt_lo),
        .legal   (gnt_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= PORT_D;
            cur_port   <= PORT_IF;
            lat_size   <= SZ_W;
            lat_unsign <= 1'b0;
            lat_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_done    <= 1'b0;
            if_err     <= 1'b0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            if_done <= 1'b0;
            if_err  <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        last_grant <= gnt_port;
                        if (gnt_legal) begin
                            state    <= ACCESS;
                            cur_port <= gnt_port;
                            lat_size <= gnt_size;
                            if (gnt_port == PORT_IF) begin
                                mem_addr   <= if_addr;
                                lat_we     <= 1'b0;
                                lat_unsign <= 1'b0;
                            end else begin
                                mem_addr   <= d_addr;
                                lat_we     <= d_we;
                                lat_unsign <= d_unsign;
                                mem_wdata  <= d_wdata;
                            end
                        end else if (gnt_port == PORT_IF) begin
                            if_done <= 1'b1;
                            if_err  <= 1'b1;
                        end else begin
                            d_done <= 1'b1;
                            d_err  <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    state <= IDLE;
                    if (cur_port == PORT_IF) begin
                        if_rdata <= mem_rdata;
                        if_done  <= 1'b1;
                    end else begin
                        if (!lat_we)
                            d_rdata <= mem_rdata;
                        d_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Memory controls decode only from registered state, so they are glitch-free to the RAM.
    assign busy       = (state == ACCESS);
    assign mem_read   = busy && !lat_we;
    assign mem_write  = busy && lat_we;
    assign mem_by     = busy && (lat_size == SZ_B);
    assign mem_half   = busy && (lat_size == SZ_H);
    assign mem_unsign = busy && lat_unsign;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 256-byte memory, directed requesters, queue scoreboard.
// Expected completions are queued by the stimulus and consumed by a negedge monitor.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_done, if_err;
    logic        d_req, d_we, d_by, d_half, d_unsign;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        d_done, d_err;
    logic        mem_read, mem_write, mem_by, mem_half, mem_unsign;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_done    (if_done),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_by       (d_by),
        .d_half     (d_half),
        .d_unsign   (d_unsign),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .d_err      (d_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_by     (mem_by),
        .mem_half   (mem_half),
        .mem_unsign (mem_unsign),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    // Behavioural memory: reset image loaded on the first clock edge.
    logic [7:0] mem [256];
    logic       mem_ready = 1'b0;
    logic [7:0] b0, b1, b2, b3;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[0]   <= 8'h13;
            mem[4]   <= 8'hB7;
            mem[5]   <= 8'h10;
            mem[104] <= 8'h09;
            mem_ready <= 1'b1;
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (!mem_by) mem[mem_addr + 8'd1] <= mem_wdata[15:8];
            if (!mem_by && !mem_half) begin
                mem[mem_addr + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        b0 = mem[mem_addr];
        b1 = mem[mem_addr + 8'd1];
        b2 = mem[mem_addr + 8'd2];
        b3 = mem[mem_addr + 8'd3];
        if (mem_by)
            mem_rdata = {{24{b0[7] & ~mem_unsign}}, b0};
        else if (mem_half)
            mem_rdata = {{16{b1[7] & ~mem_unsign}}, b1, b0};
        else
            mem_rdata = {b3, b2, b1, b0};
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t if_q[$];
    exp_t d_q[$];
    logic ord_q[$];
    int   checks = 0;
    int   failures = 0;
    int   acc_cnt = 0;
    int   rd_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_if(input logic [31:0] r, input logic e);
        exp_t x;
        x.rdata = r;
        x.err = e;
        if_q.push_back(x);
        ord_q.push_back(1'b0);
    endtask

    task automatic exp_d(input logic [31:0] r, input logic e);
        exp_t x;
        x.rdata = r;
        x.err = e;
        d_q.push_back(x);
        ord_q.push_back(1'b1);
    endtask

    task automatic check_done(input logic port, input logic [31:0] rdata, input logic err);
        exp_t e;
        logic p;
        if (ord_q.size() == 0 || (port ? d_q.size() : if_q.size()) == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_done: got done, expected none", port ? "d" : "if");
            return;
        end
        p = ord_q.pop_front();
        if (port) begin
            e = d_q.pop_front();
            chk("d_order", {31'd0, p}, 32'd1);
            chk("d_rdata", rdata, e.rdata);
            chk("d_err", {31'd0, err}, {31'd0, e.err});
        end else begin
            e = if_q.pop_front();
            chk("if_order", {31'd0, p}, 32'd0);
            chk("if_rdata", rdata, e.rdata);
            chk("if_err", {31'd0, err}, {31'd0, e.err});
        end
    endtask

    always @(negedge clk) begin
        if (mem_read || mem_write) acc_cnt++;
        if (mem_read) rd_cnt++;
        if (if_done && d_done) begin
            checks++;
            failures++;
            $display("FAIL dual_done: got both dones, expected at most one");
        end
        if (if_done) check_done(1'b0, if_rdata, if_err);
        if (d_done) check_done(1'b1, d_rdata, d_err);
    end

    task automatic wait_done(input logic port, output int n);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (port ? d_done : if_done) break;
        end
        if (n > 40) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got no done in 40 cycles, expected done", port ? "d" : "if");
        end
    endtask

    task automatic do_fetch(input logic [7:0] addr, input int lat);
        int n;
        @(posedge clk); #1;
        if_addr = addr;
        if_req  = 1'b1;
        wait_done(1'b0, n);
        chk("if_latency", n, lat);
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic by, input logic half, input logic uns,
                           input logic [7:0] addr, input logic [31:0] wdata, input int lat);
        int n;
        @(posedge clk); #1;
        d_we = we; d_by = by; d_half = half; d_unsign = uns;
        d_addr = addr; d_wdata = wdata;
        d_req = 1'b1;
        wait_done(1'b1, n);
        chk("d_latency", n, lat);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    logic [7:0]  f_addrs [4];
    logic [7:0]  l_addrs [4];
    int          acc0;
    int          rd0;

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_by = 1'b0; d_half = 1'b0; d_unsign = 1'b0;
        d_addr = '0; d_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dones", {28'd0, if_done, if_err, d_done, d_err}, 32'd0);
        chk("rst_ctrl", {26'd0, mem_read, mem_write, mem_by, mem_half, mem_unsign, busy}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Single fetch: word at 0, one read cycle
        rd0 = rd_cnt;
        exp_if(32'h0000_0013, 1'b0);
        do_fetch(8'd0, 3);
        chk("t1_read_cycles", rd_cnt - rd0, 32'd1);

        // Simultaneous first requests after reset: fetch wins, data follows gap-free
        do_reset();
        exp_if(32'h0000_10B7, 1'b0);
        exp_d(32'h0000_0009, 1'b0);
        fork
            do_fetch(8'd4, 3);
            do_data(1'b0, 1'b0, 1'b0, 1'b0, 8'd104, 32'd0, 5);
        join

        // Store byte, then signed and unsigned byte loads
        exp_d(32'h0000_0009, 1'b0);
        do_data(1'b1, 1'b1, 1'b0, 1'b0, 8'd110, 32'h0000_0080, 3);
        exp_d(32'hFFFF_FF80, 1'b0);
        do_data(1'b0, 1'b1, 1'b0, 1'b0, 8'd110, 32'd0, 3);
        exp_d(32'h0000_0080, 1'b0);
        do_data(1'b0, 1'b1, 1'b0, 1'b1, 8'd110, 32'd0, 3);

        // Misaligned accesses: error one cycle after grant, no memory traffic
        acc0 = acc_cnt;
        exp_if(32'h0000_10B7, 1'b1);
        do_fetch(8'd2, 2);
        exp_d(32'h0000_0080, 1'b1);
        do_data(1'b0, 1'b0, 1'b0, 1'b0, 8'd101, 32'd0, 2);
        exp_d(32'h0000_0080, 1'b1);
        do_data(1'b0, 1'b0, 1'b1, 1'b0, 8'd103, 32'd0, 2);
        chk("t4_no_mem_access", acc_cnt - acc0, 32'd0);

        // Both ports requesting continuously: strict F/D alternation
        f_addrs[0] = 8'd0;   f_addrs[1] = 8'd4;   f_addrs[2] = 8'd0;   f_addrs[3] = 8'd4;
        l_addrs[0] = 8'd104; l_addrs[1] = 8'd108; l_addrs[2] = 8'd104; l_addrs[3] = 8'd108;
        for (int i = 0; i < 2; i++) begin
            exp_if(32'h0000_0013, 1'b0);
            exp_d(32'h0000_0009, 1'b0);
            exp_if(32'h0000_10B7, 1'b0);
            exp_d(32'h0080_0000, 1'b0);
        end
        @(posedge clk); #1;
        d_we = 1'b0; d_by = 1'b0; d_half = 1'b0; d_unsign = 1'b0;
        fork
            begin
                int n;
                for (int i = 0; i < 4; i++) begin
                    if_addr = f_addrs[i];
                    if_req = 1'b1;
                    wait_done(1'b0, n);
                    @(posedge clk); #1;
                end
                if_req = 1'b0;
            end
            begin
                int n;
                for (int j = 0; j < 4; j++) begin
                    d_addr = l_addrs[j];
                    d_req = 1'b1;
                    wait_done(1'b1, n);
                    @(posedge clk); #1;
                end
                d_req = 1'b0;
            end
        join

        // Reset during a load's ACCESS cycle: no completion, then a clean retry
        @(posedge clk); #1;
        d_we = 1'b0; d_by = 1'b0; d_half = 1'b0; d_addr = 8'd104;
        d_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_busy_in_access", {31'd0, busy}, 32'd1);
        chk("t6_read_in_access", {31'd0, mem_read}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        d_req = 1'b0;
        @(negedge clk);
        chk("t6_no_done", {30'd0, d_done, d_err}, 32'd0);
        chk("t6_idle", {29'd0, busy, mem_read, mem_write}, 32'd0);
        chk("t6_d_rdata_clr", d_rdata, 32'd0);
        chk("t6_if_rdata_clr", if_rdata, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        exp_d(32'h0000_0009, 1'b0);
        do_data(1'b0, 1'b0, 1'b0, 1'b0, 8'd104, 32'd0, 3);

        repeat (4) @(negedge clk);
        chk("if_q_drained", if_q.size(), 32'd0);
        chk("d_q_drained", d_q.size(), 32'd0);
        chk("ord_q_drained", ord_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
